fpaddsub_align_shifter_pipe: RTL and testbench

- Parametrised, pipelined mantissa-alignment right shifter for the FP add/sub datapath.
- Shifts the smaller operand's mantissa right by the exponent difference and produces the sticky bit.
- Covers the whole shift in one block: log-levels are distributed over a configurable number of register stages, under valid/ready flow control.
- Replaces the fixed two-module split alignment: coarse levels first, then fine levels.

---
 rtl/fpaddsub_pkg.sv | 34 +++
 rtl/fpaddsub_align_level.sv | 26 ++
 rtl/fpaddsub_align_shifter_pipe.sv | 94 +++++++++
 tb/tb_fpaddsub_align_shifter_pipe.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/fpaddsub_pkg.sv
// fpaddsub_pkg: shared types and elaboration helpers for the FP add/sub alignment path
package fpaddsub_pkg;

    localparam int MANT_W    = 32;
    localparam int SHIFT_W_D = 5;
    localparam int TAG_W_D   = 1;

    typedef struct packed {
        logic [MANT_W-1:0]    mant;
        logic [SHIFT_W_D-1:0] shift;
        logic                 sticky;
        logic [TAG_W_D-1:0]   tag;
    } align_beat_t;

    function automatic int clog2(input int n);
        int r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic int stage_hi(input int s, input int shift_w, input int stages);
        return shift_w - 1 - s * ((shift_w + stages - 1) / stages);
    endfunction

    function automatic int stage_lo(input int s, input int shift_w, input int stages);
        int lo = shift_w - (s + 1) * ((shift_w + stages - 1) / stages);
        return lo < 0 ? 0 : lo;
    endfunction

    function automatic bit level_in_stage(input int k, input int s, input int shift_w, input int stages);
        return k <= stage_hi(s, shift_w, stages) && k >= stage_lo(s, shift_w, stages);
    endfunction

endpackage

// File: rtl/fpaddsub_align_level.sv
// fpaddsub_align_level: one conditional right shift by 2^K with sticky collection
module fpaddsub_align_level
    import fpaddsub_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int K     = 0
) (
    input  logic             en,
    input  logic [WIDTH-1:0] mant,
    input  logic             sticky,
    output logic [WIDTH-1:0] res_mant,
    output logic             res_sticky
);

    generate
        if (K >= clog2(WIDTH)) begin : g_flush
            assign res_mant   = en ? '0 : mant;
            assign res_sticky = sticky | (en & (|mant));
        end else begin : g_shift
            localparam int SH = 1 << K;
            assign res_mant   = en ? mant >> SH : mant;
            assign res_sticky = sticky | (en & (|mant[SH-1:0]));
        end
    endgenerate

endmodule

// File: rtl/fpaddsub_align_shifter_pipe.sv
// fpaddsub_align_shifter_pipe: pipelined mantissa-alignment right shifter with sticky and valid/ready
module fpaddsub_align_shifter_pipe
    import fpaddsub_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHIFT_W = 5,
    parameter int STAGES  = 2,
    parameter int TAG_W   = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_mant,
    input  logic [SHIFT_W-1:0] in_shift,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_mant,
    output logic               out_sticky,
    output logic [TAG_W-1:0]   out_tag
);

    typedef struct packed {
        logic [WIDTH-1:0]   mant;
        logic [SHIFT_W-1:0] shift;
        logic               sticky;
        logic [TAG_W-1:0]   tag;
    } beat_t;

    beat_t             r [STAGES];
    logic [STAGES-1:0] v;
    logic [STAGES-1:0] ld;

    genvar s, j;
    generate
        for (s = 0; s < STAGES; s++) begin : g_stage
            beat_t            d;
            beat_t            q;
            logic             pv;
            logic             vq;
            logic [WIDTH-1:0] m  [SHIFT_W+1];
            logic             st [SHIFT_W+1];
            if (s == 0) begin : g_src
                assign d  = {in_mant, in_shift, 1'b0, in_tag};
                assign pv = in_valid;
            end else begin : g_src
                assign d  = r[s-1];
                assign pv = v[s-1];
            end
            if (s == STAGES - 1) begin : g_ld
                assign ld[s] = !v[s] || out_ready;
            end else begin : g_ld
                assign ld[s] = !v[s] || ld[s+1];
            end
            assign m[0]  = d.mant;
            assign st[0] = d.sticky;
            for (j = 0; j < SHIFT_W; j++) begin : g_lvl
                localparam int K = SHIFT_W - 1 - j;
                if (level_in_stage(K, s, SHIFT_W, STAGES)) begin : g_on
                    fpaddsub_align_level #(.WIDTH(WIDTH), .K(K)) u_level (
                        .en        (d.shift[K]),
                        .mant      (m[j]),
                        .sticky    (st[j]),
                        .res_mant  (m[j+1]),
                        .res_sticky(st[j+1])
                    );
                end else begin : g_off
                    assign m[j+1]  = m[j];
                    assign st[j+1] = st[j];
                end
            end
            // Stage slice: take a beat whenever this stage is empty or its occupant moves on
            always_ff @(posedge clk) begin
                if (rst) begin
                    vq <= 1'b0;
                    q  <= '0;
                end else if (ld[s]) begin
                    vq <= pv;
                    if (pv) q <= {m[SHIFT_W], d.shift, st[SHIFT_W], d.tag};
                end
            end
            assign v[s] = vq;
            assign r[s] = q;
        end
    endgenerate

    assign in_ready   = ld[0];
    assign out_valid  = v[STAGES-1];
    assign out_mant   = r[STAGES-1].mant;
    assign out_sticky = r[STAGES-1].sticky;
    assign out_tag    = r[STAGES-1].tag;

endmodule

// File: tb/tb_fpaddsub_align_shifter_pipe.sv
// tb_fpaddsub_align_shifter_pipe: scoreboard bench over several pipeline depths
module tb_fpaddsub_align_shifter_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : gi
            localparam int ST = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 3 : 5;

            typedef struct {
                logic [31:0] m;
                logic        s;
                logic [3:0]  t;
                int          c;
                bit          lat;
            } exp_t;

            logic        rst, in_valid, in_ready, out_valid, out_ready, out_sticky;
            logic [31:0] in_mant, out_mant;
            logic [5:0]  in_shift;
            logic [3:0]  in_tag, out_tag;
            exp_t        q[$];
            bit          rnd_ready = 1'b0;
            bit          lat_mode = 1'b0;
            bit          drop = 1'b0;
            bit          fin = 1'b0;
            int          ntag = 0;

            fpaddsub_align_shifter_pipe #(.WIDTH(32), .SHIFT_W(6), .STAGES(ST), .TAG_W(4)) dut (
                .clk       (clk),
                .rst       (rst),
                .in_valid  (in_valid),
                .in_ready  (in_ready),
                .in_mant   (in_mant),
                .in_shift  (in_shift),
                .in_tag    (in_tag),
                .out_valid (out_valid),
                .out_ready (out_ready),
                .out_mant  (out_mant),
                .out_sticky(out_sticky),
                .out_tag   (out_tag)
            );

            task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
                checks++;
                if (act !== exp) begin
                    errors++;
                    $display("FAIL stages=%0d %s: got %0h expected %0h", ST, name, act, exp);
                end
            endtask

            function automatic exp_t model(input logic [31:0] m, input int sh, input logic [3:0] t);
                exp_t e;
                e.m = sh >= 32 ? 32'd0 : m >> sh;
                e.s = 1'b0;
                for (int i = 0; i < 32; i++) if (i < sh) e.s |= m[i];
                e.t = t;
                e.c = 0;
                e.lat = 1'b0;
                return e;
            endfunction

            task automatic send(input logic [31:0] m, input logic [5:0] sh);
                exp_t e;
                int   w = 0;
                @(negedge clk);
                in_valid = 1'b1;
                in_mant  = m;
                in_shift = sh;
                in_tag   = 4'(ntag);
                forever begin
                    #1;
                    if (in_ready) begin
                        e = model(m, int'(sh), 4'(ntag));
                        e.c = cyc;
                        e.lat = lat_mode;
                        q.push_back(e);
                        ntag++;
                        @(posedge clk);
                        #1 in_valid = 1'b0;
                        return;
                    end
                    drop = 1'b1;
                    if (++w > 200) begin
                        chk("accept_timeout", 64'(w), 64'd0);
                        in_valid = 1'b0;
                        return;
                    end
                    @(negedge clk);
                end
            endtask

            task automatic drain();
                int w = 0;
                while (q.size() != 0 && w < 300) begin
                    @(negedge clk);
                    w++;
                end
                chk("drain_left", 64'(q.size()), 64'd0);
            endtask

            // random downstream back-pressure
            initial forever begin
                @(negedge clk);
                if (rnd_ready) out_ready = ($urandom % 3) != 0;
            end

            // monitor: compare each transferred beat and check hold-while-stalled
            initial begin
                logic        held = 1'b0;
                logic [31:0] hm;
                logic        hs;
                logic [3:0]  ht;
                exp_t        e;
                forever begin
                    @(negedge clk);
                    #2;
                    if (rst) begin
                        held = 1'b0;
                    end else begin
                        if (held) begin
                            chk("hold_valid", 64'(out_valid), 64'd1);
                            chk("hold_data", {out_mant, 27'd0, out_sticky, out_tag}, {hm, 27'd0, hs, ht});
                        end
                        if (out_valid && out_ready) begin
                            if (q.size() == 0) begin
                                chk("unexpected_beat", {32'd0, out_mant}, 64'hdead_beef_0000_0000);
                            end else begin
                                e = q.pop_front();
                                chk("mant", 64'(out_mant), 64'(e.m));
                                chk("sticky", 64'(out_sticky), 64'(e.s));
                                chk("tag", 64'(out_tag), 64'(e.t));
                                if (e.lat) chk("latency", 64'(cyc - e.c), 64'(ST));
                            end
                        end
                        held = out_valid && !out_ready;
                        hm = out_mant;
                        hs = out_sticky;
                        ht = out_tag;
                    end
                end
            end

            // stimulus: directed vectors, stall, reset flush, random sweep
            initial begin
                rst = 1'b1;
                in_valid = 1'b0;
                in_mant = '0;
                in_shift = '0;
                in_tag = '0;
                out_ready = 1'b1;
                repeat (3) @(negedge clk);
                rst = 1'b0;
                #1;
                chk("rst_out_valid", 64'(out_valid), 64'd0);
                chk("rst_out_data", {out_mant, 27'd0, out_sticky, out_tag}, 64'd0);
                chk("rst_in_ready", 64'(in_ready), 64'd1);
                lat_mode = 1'b1;
                send(32'h8000_0001, 6'd4);
                send(32'hFFFF_FFFF, 6'd31);
                send(32'h1234_5678, 6'd0);
                send(32'h0000_0010, 6'd40);
                send(32'h0000_0000, 6'd40);
                send(32'h0000_0001, 6'd32);
                send(32'hFFFF_FFFF, 6'd63);
                send(32'hA5A5_A5A5, 6'd16);
                drain();
                lat_mode = 1'b0;
                drop = 1'b0;
                fork
                    for (int i = 0; i < 8; i++) send($urandom, 6'($urandom_range(0, 40)));
                    begin
                        repeat (3) @(negedge clk);
                        out_ready = 1'b0;
                        repeat (4) @(negedge clk);
                        out_ready = 1'b1;
                    end
                join
                chk("in_ready_dropped", 64'(drop), 64'd1);
                drain();
                out_ready = 1'b0;
                repeat (ST < 2 ? 1 : 2) send($urandom, 6'($urandom_range(0, 63)));
                @(negedge clk);
                rst = 1'b1;
                in_valid = 1'b1;
                in_mant = $urandom;
                q.delete();
                @(negedge clk);
                rst = 1'b0;
                in_valid = 1'b0;
                #1;
                chk("flush_out_valid", 64'(out_valid), 64'd0);
                chk("flush_in_ready", 64'(in_ready), 64'd1);
                out_ready = 1'b1;
                repeat (ST + 4) @(negedge clk);
                rnd_ready = 1'b1;
                for (int i = 0; i < 300; i++) begin
                    if ($urandom % 4 == 0) @(negedge clk);
                    send($urandom, 6'($urandom % 4 == 0 ? $urandom_range(32, 63) : $urandom_range(0, 31)));
                end
                @(negedge clk);
                rnd_ready = 1'b0;
                out_ready = 1'b1;
                drain();
                fin = 1'b1;
            end
        end
    endgenerate

    initial begin
        fork
            wait (gi[0].fin && gi[1].fin && gi[2].fin && gi[3].fin);
            begin
                repeat (50000) @(posedge clk);
                checks++;
                errors++;
                $display("FAIL global_timeout: got unfinished expected finished");
            end
        join_any
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
